// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolution bundle of the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             i_pred_valid;
  logic [XLEN-1:0]  i_pred_pc;
  logic             o_pred_taken;
  logic             i_res_valid;
  logic             i_res_branch;
  logic [XLEN-1:0]  i_res_pc;
  logic             i_res_taken;
  logic             i_res_pred;
  logic             o_flush;
  logic             o_flush_taken;
  logic [CNT_W-1:0] o_num_branches;
  logic [CNT_W-1:0] o_num_mispred;

  modport master (
    output i_pred_valid, i_pred_pc, i_res_valid, i_res_branch, i_res_pc,
           i_res_taken, i_res_pred,
    input  o_pred_taken, o_flush, o_flush_taken, o_num_branches, o_num_mispred
  );

  modport slave (
    input  i_pred_valid, i_pred_pc, i_res_valid, i_res_branch, i_res_pc,
           i_res_taken, i_res_pred,
    output o_pred_taken, o_flush, o_flush_taken, o_num_branches, o_num_mispred
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter branch predictor with registered misprediction flush
// and saturating branch / misprediction statistics.
module branch_predictor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  branch_predictor_if.slave  bp
);

  localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam logic [1:0]  WEAK_NT = 2'b01;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             update;
  logic             mispred;
  logic             flush_q;
  logic             flush_taken_q;
  logic [CNT_W-1:0] num_branches_q;
  logic [CNT_W-1:0] num_mispred_q;
  logic             unused_pc_bits;

  // Word-aligned PC bits select the counter; byte offset is ignored.
  assign pred_idx = bp.i_pred_pc[IDX_W+1:2];
  assign res_idx  = bp.i_res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bp.i_pred_pc[XLEN-1:IDX_W+2], bp.i_pred_pc[1:0],
                            bp.i_res_pc[XLEN-1:IDX_W+2], bp.i_res_pc[1:0]};

  // Lookup reads the pre-update table value; no write bypass.
  assign bp.o_pred_taken = bp.i_pred_valid & bht[pred_idx][1];

  assign update  = bp.i_res_valid & bp.i_res_branch;
  assign mispred = update & (bp.i_res_taken ^ bp.i_res_pred);

  // Counter table training with saturation at both ends.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht[i] <= WEAK_NT;
      end
    end else if (update) begin
      if (bp.i_res_taken) begin
        if (bht[res_idx] != 2'b11) bht[res_idx] <= bht[res_idx] + 2'd1;
      end else begin
        if (bht[res_idx] != 2'b00) bht[res_idx] <= bht[res_idx] - 2'd1;
      end
    end
  end

  // One-cycle flush pulse; redirect direction latched only on a mispredict.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      flush_q       <= 1'b0;
      flush_taken_q <= 1'b0;
    end else begin
      flush_q <= mispred;
      if (mispred) flush_taken_q <= bp.i_res_taken;
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      num_branches_q <= '0;
      num_mispred_q  <= '0;
    end else begin
      if (update && (num_branches_q != {CNT_W{1'b1}})) begin
        num_branches_q <= num_branches_q + CNT_W'(1);
      end
      if (mispred && (num_mispred_q != {CNT_W{1'b1}})) begin
        num_mispred_q <= num_mispred_q + CNT_W'(1);
      end
    end
  end

  assign bp.o_flush        = flush_q;
  assign bp.o_flush_taken  = flush_taken_q;
  assign bp.o_num_branches = num_branches_q;
  assign bp.o_num_mispred  = num_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a behavioural table model.
module tb_branch_predictor;

  localparam int    N_ENT   = 64;
  localparam longint MAX32  = 64'h0000_0000_FFFF_FFFF;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int     m_bht [N_ENT];
  longint m_br;
  longint m_mp;
  bit     m_flush;
  bit     m_ft;

  branch_predictor_if #(.XLEN(32), .CNT_W(32)) bif ();
  branch_predictor_if #(.XLEN(32), .CNT_W(4))  bif2 ();

  branch_predictor #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) dut (
    .i_clk (clk), .i_rstn(rst_n), .bp(bif)
  );
  branch_predictor #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(4)) dut2 (
    .i_clk (clk), .i_rstn(rst_n), .bp(bif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % N_ENT);
  endfunction

  function automatic bit exp_pred(logic [31:0] pc);
    return m_bht[idx_of(pc)] >= 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_ENT; i++) m_bht[i] = 1;
    m_br = 0; m_mp = 0; m_flush = 0; m_ft = 0;
  endtask

  // Apply the resolution rules to the model for one clock edge.
  task automatic model_apply();
    int  i;
    bit  mis;
    if (bif.i_res_valid && bif.i_res_branch) begin
      i   = idx_of(bif.i_res_pc);
      mis = (bif.i_res_taken != bif.i_res_pred);
      if (bif.i_res_taken) m_bht[i] = (m_bht[i] == 3) ? 3 : m_bht[i] + 1;
      else                 m_bht[i] = (m_bht[i] == 0) ? 0 : m_bht[i] - 1;
      if (m_br < MAX32) m_br++;
      if (mis && m_mp < MAX32) m_mp++;
      m_flush = mis;
      if (mis) m_ft = bif.i_res_taken;
    end else begin
      m_flush = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_apply();
    @(negedge clk);
  endtask

  task automatic set_lookup(bit pv, logic [31:0] pc);
    bif.i_pred_valid = pv;
    bif.i_pred_pc    = pc;
  endtask

  task automatic set_res(bit rv, bit rb, logic [31:0] pc, bit rt, bit rp);
    bif.i_res_valid  = rv;
    bif.i_res_branch = rb;
    bif.i_res_pc     = pc;
    bif.i_res_taken  = rt;
    bif.i_res_pred   = rp;
  endtask

  task automatic resolve(logic [31:0] pc, bit rt, bit rp);
    set_res(1, 1, pc, rt, rp);
    tick();
    set_res(0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_lookup(1, 32'h100);
    repeat (2) @(negedge clk);
    checks++; if (bif.o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b exp 0", bif.o_flush); end
    checks++; if (bif.o_flush_taken !== 1'b0) begin errors++; $display("FAIL reset_flush_taken got %0b exp 0", bif.o_flush_taken); end
    checks++; if (bif.o_num_branches !== 32'd0) begin errors++; $display("FAIL reset_branches got %0d exp 0", bif.o_num_branches); end
    checks++; if (bif.o_num_mispred !== 32'd0) begin errors++; $display("FAIL reset_mispred got %0d exp 0", bif.o_num_mispred); end
    checks++; if (bif.o_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %0b exp 0", bif.o_pred_taken); end
    rst_n = 1'b1;
    set_lookup(0, 32'h100);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b0) begin errors++; $display("FAIL pred_invalid got %0b exp 0", bif.o_pred_taken); end
  endtask

  task automatic test_basic();
    do_reset();
    set_lookup(1, 32'h100);
    set_res(1, 1, 32'h100, 1, 0);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b0) begin errors++; $display("FAIL basic_pred0 got %0b exp 0", bif.o_pred_taken); end
    tick();
    set_res(0, 0, 32'h0, 0, 0);
    #1;
    checks++; if (bif.o_flush !== 1'b1) begin errors++; $display("FAIL basic_flush got %0b exp 1", bif.o_flush); end
    checks++; if (bif.o_flush_taken !== 1'b1) begin errors++; $display("FAIL basic_flush_taken got %0b exp 1", bif.o_flush_taken); end
    checks++; if (bif.o_num_mispred !== 32'd1) begin errors++; $display("FAIL basic_mispred got %0d exp 1", bif.o_num_mispred); end
    checks++; if (bif.o_num_branches !== 32'd1) begin errors++; $display("FAIL basic_branches got %0d exp 1", bif.o_num_branches); end
    checks++; if (bif.o_pred_taken !== 1'b1) begin errors++; $display("FAIL basic_pred1 got %0b exp 1", bif.o_pred_taken); end
    tick();
    checks++; if (bif.o_flush !== 1'b0) begin errors++; $display("FAIL basic_flush_width got %0b exp 0", bif.o_flush); end
    checks++; if (bif.o_flush_taken !== 1'b1) begin errors++; $display("FAIL basic_ft_hold got %0b exp 1", bif.o_flush_taken); end
  endtask

  task automatic test_saturation();
    bit exp_seq [10];
    bit tk_seq  [10];
    do_reset();
    set_lookup(1, 32'h40);
    for (int i = 0; i < 4; i++) resolve(32'h40, 1, exp_pred(32'h40));
    #1;
    checks++; if (bif.o_pred_taken !== 1'b1) begin errors++; $display("FAIL sat_up got %0b exp 1", bif.o_pred_taken); end
    // Expected prediction after each resolution: 11->10,01,00,00,00 then 01,10,11,11,11.
    for (int i = 0; i < 10; i++) tk_seq[i] = (i >= 5);
    exp_seq = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      resolve(32'h40, tk_seq[i], exp_pred(32'h40));
      #1;
      checks++;
      if (bif.o_pred_taken !== exp_seq[i] || bif.o_pred_taken !== exp_pred(32'h40)) begin
        errors++; $display("FAIL sat_step%0d got %0b exp %0b", i, bif.o_pred_taken, exp_seq[i]);
      end
    end
  endtask

  task automatic test_alias();
    do_reset();
    resolve(32'h0, 1, 0);
    resolve(32'h0, 1, 1);
    set_lookup(1, 32'h100);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b1) begin errors++; $display("FAIL alias_hit got %0b exp 1", bif.o_pred_taken); end
    set_lookup(1, 32'h4);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_miss got %0b exp 0", bif.o_pred_taken); end
    set_lookup(1, 32'h3);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b1) begin errors++; $display("FAIL alias_lowbits got %0b exp 1", bif.o_pred_taken); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_lookup(1, 32'h14);
    set_res(1, 1, 32'h14, 1, 0);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old got %0b exp 0", bif.o_pred_taken); end
    tick();
    set_res(0, 0, 32'h0, 0, 0);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_new got %0b exp 1", bif.o_pred_taken); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_lookup(0, 32'h0);
    set_res(1, 0, 32'h20, 1, 0);
    tick();
    checks++; if (bif.o_flush !== 1'b0) begin errors++; $display("FAIL nonbranch_flush got %0b exp 0", bif.o_flush); end
    checks++; if (bif.o_num_branches !== 32'd0) begin errors++; $display("FAIL nonbranch_branches got %0d exp 0", bif.o_num_branches); end
    checks++; if (bif.o_num_mispred !== 32'd0) begin errors++; $display("FAIL nonbranch_mispred got %0d exp 0", bif.o_num_mispred); end
    set_lookup(1, 32'h20);
    #1;
    checks++; if (bif.o_pred_taken !== 1'b0) begin errors++; $display("FAIL nonbranch_table got %0b exp 0", bif.o_pred_taken); end
    for (int i = 0; i < 3; i++) begin
      set_res(1, 1, 32'h30 + 32'(i * 4), (i != 1), (i == 1));
      tick();
      checks++; if (bif.o_flush !== 1'b1) begin errors++; $display("FAIL b2b_flush%0d got %0b exp 1", i, bif.o_flush); end
      checks++; if (bif.o_flush_taken !== m_ft) begin errors++; $display("FAIL b2b_ft%0d got %0b exp %0b", i, bif.o_flush_taken, m_ft); end
    end
    set_res(0, 0, 32'h0, 0, 0);
    tick();
    checks++; if (bif.o_flush !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b exp 0", bif.o_flush); end
    checks++; if (bif.o_num_mispred !== 32'd3) begin errors++; $display("FAIL b2b_mispred got %0d exp 3", bif.o_num_mispred); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      set_lookup($urandom_range(0, 3) != 0, pc);
      if ($urandom_range(0, 1) == 0) pc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
      set_res($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) == 1) : exp_pred(pc));
      #1;
      checks++;
      if (bif.o_pred_taken !== (bif.i_pred_valid & exp_pred(bif.i_pred_pc))) begin
        errors++; $display("FAIL rnd_pred n=%0d got %0b exp %0b", n, bif.o_pred_taken, bif.i_pred_valid & exp_pred(bif.i_pred_pc));
      end
      tick();
      checks++;
      if (bif.o_flush !== m_flush || bif.o_flush_taken !== m_ft ||
          bif.o_num_branches !== 32'(m_br) || bif.o_num_mispred !== 32'(m_mp)) begin
        errors++;
        $display("FAIL rnd_state n=%0d got fl=%0b ft=%0b br=%0d mp=%0d exp fl=%0b ft=%0b br=%0d mp=%0d", n,
                 bif.o_flush, bif.o_flush_taken, bif.o_num_branches, bif.o_num_mispred, m_flush, m_ft, m_br, m_mp);
      end
    end
    set_res(0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_async_reset();
    set_lookup(0, 32'h0);
    set_res(1, 1, 32'h8, ~exp_pred(32'h8), exp_pred(32'h8));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bif.o_flush !== 1'b0 || bif.o_flush_taken !== 1'b0) begin errors++; $display("FAIL arst_flush got %0b/%0b exp 0/0", bif.o_flush, bif.o_flush_taken); end
    checks++; if (bif.o_num_branches !== 32'd0 || bif.o_num_mispred !== 32'd0) begin errors++; $display("FAIL arst_counts got %0d/%0d exp 0/0", bif.o_num_branches, bif.o_num_mispred); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bif.o_flush !== 1'b0) begin errors++; $display("FAIL arst_hold got %0b exp 0", bif.o_flush); end
    set_res(0, 0, 32'h0, 0, 0);
    rst_n = 1'b1;
    tick();
    checks++; if (bif.o_flush !== 1'b0) begin errors++; $display("FAIL arst_no_pulse got %0b exp 0", bif.o_flush); end
    // Every entry must be weak not-taken: predicts 0, flips to 1 after one taken.
    for (int i = 0; i < N_ENT; i++) begin
      set_lookup(1, 32'(i) << 2);
      set_res(1, 1, 32'(i) << 2, 1, 0);
      #1;
      checks++; if (bif.o_pred_taken !== 1'b0) begin errors++; $display("FAIL arst_entry%0d_before got %0b exp 0", i, bif.o_pred_taken); end
      tick();
      set_res(0, 0, 32'h0, 0, 0);
      #1;
      checks++; if (bif.o_pred_taken !== exp_pred(32'(i) << 2)) begin errors++; $display("FAIL arst_entry%0d_after got %0b exp %0b", i, bif.o_pred_taken, exp_pred(32'(i) << 2)); end
    end
  endtask

  task automatic test_cnt_sat();
    int exp_n;
    do_reset();
    bif2.i_res_valid  = 1'b1;
    bif2.i_res_branch = 1'b1;
    bif2.i_res_pc     = 32'h0;
    bif2.i_res_taken  = 1'b1;
    bif2.i_res_pred   = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      tick();
      exp_n = (n > 15) ? 15 : n;
      checks++;
      if (bif2.o_num_mispred !== 4'(exp_n) || bif2.o_num_branches !== 4'(exp_n) || bif2.o_flush !== 1'b1) begin
        errors++; $display("FAIL cnt_sat n=%0d got mp=%0d br=%0d fl=%0b exp %0d/%0d/1", n,
                           bif2.o_num_mispred, bif2.o_num_branches, bif2.o_flush, exp_n, exp_n);
      end
    end
    bif2.i_res_valid = 1'b0;
    tick();
    checks++; if (bif2.o_num_mispred !== 4'd15 || bif2.o_flush !== 1'b0) begin errors++; $display("FAIL cnt_sat_hold got mp=%0d fl=%0b exp 15/0", bif2.o_num_mispred, bif2.o_flush); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_lookup(0, 32'h0);
    set_res(0, 0, 32'h0, 0, 0);
    bif2.i_pred_valid = 1'b0;
    bif2.i_pred_pc    = 32'h0;
    bif2.i_res_valid  = 1'b0;
    bif2.i_res_branch = 1'b0;
    bif2.i_res_pc     = 32'h0;
    bif2.i_res_taken  = 1'b0;
    bif2.i_res_pred   = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_cnt_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
